// File: rtl/emu_transactor_gen.sv
// Co-emulation transactor: the host stages stimulus bytes, applies them atomically, runs a
// counted number of DUT clock cycles, then captures the DUT response for byte-wise readback.
module emu_transactor_gen #(
  parameter int NUM_STIM_BYTES = 2,
  parameter int NUM_OUT_BYTES  = 4,
  parameter int ADDR_W         = 3,
  parameter int HALF_PERIOD    = 1
) (
  input  logic                        clk_emu,
  input  logic                        rst_emu_n,
  input  logic [7:0]                  Din_emu,
  input  logic [ADDR_W-1:0]           Addr_emu,
  input  logic                        wr_emu,
  input  logic                        rd_emu,
  input  logic                        load_emu,
  input  logic                        step_emu,
  input  logic                        get_emu,
  output logic [7:0]                  Dout_emu,
  output logic                        clk_dut,
  output logic [8*NUM_STIM_BYTES-1:0] stim_vec,
  input  logic [8*NUM_OUT_BYTES-1:0]  resp_vec,
  output logic                        busy_emu,
  output logic                        done_emu
);

  localparam int STIM_W = 8 * NUM_STIM_BYTES;
  localparam int OUT_W  = 8 * NUM_OUT_BYTES;
  localparam int PH_W   = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [7:0]        remaining_q, remaining_d;
  logic              phase_end;
  logic              is_idle;
  logic              cmd_load, cmd_step, cmd_get, cmd_wr;
  logic              capture, done_d, clk_dut_d, busy_d;
  logic [STIM_W-1:0] stim_shadow;
  logic [OUT_W-1:0]  out_shadow;
  logic [7:0]        rd_byte;

  // Host commands are only honoured in IDLE, one per edge, in fixed priority order.
  always_comb begin
    is_idle   = (state_q == IDLE);
    phase_end = (phase_q == PH_LAST);
    cmd_load  = is_idle && load_emu;
    cmd_step  = is_idle && !load_emu && step_emu;
    cmd_get   = is_idle && !load_emu && !step_emu && get_emu;
    cmd_wr    = is_idle && !load_emu && !step_emu && !get_emu && wr_emu;
  end

  always_ff @(posedge clk_emu) begin
    if (!rst_emu_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      remaining_q <= '0;
      clk_dut     <= 1'b0;
      busy_emu    <= 1'b0;
      done_emu    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      clk_dut     <= clk_dut_d;
      busy_emu    <= busy_d;
      done_emu    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (cmd_step && (Din_emu != 8'd0)) begin
          state_d     = HIGH;
          phase_d     = '0;
          remaining_d = Din_emu;
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_d = LOW;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      LOW: begin
        if (phase_end) begin
          phase_d     = '0;
          remaining_d = remaining_q - 8'd1;
          state_d     = (remaining_q == 8'd1) ? IDLE : HIGH;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        phase_d     = '0;
        remaining_d = '0;
      end
    endcase
  end

  // clk_dut mirrors the next state so it is high exactly while the FSM sits in HIGH.
  always_comb begin
    capture   = 1'b0;
    done_d    = 1'b0;
    clk_dut_d = (state_d == HIGH);
    busy_d    = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (cmd_step && (Din_emu == 8'd0)) begin
          capture = 1'b1;
          done_d  = 1'b1;
        end else if (cmd_get) begin
          capture = 1'b1;
        end
      end
      LOW: begin
        if (phase_end && (remaining_q == 8'd1)) begin
          capture = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_byte = 8'h00;
    for (int i = 0; i < NUM_OUT_BYTES; i++) begin
      if (Addr_emu == ADDR_W'(i)) rd_byte = out_shadow[8*i +: 8];
    end
  end

  // Shadow banks and readback; out-of-range addresses simply match no byte lane.
  always_ff @(posedge clk_emu) begin
    if (!rst_emu_n) begin
      stim_shadow <= '0;
      stim_vec    <= '0;
      out_shadow  <= '0;
      Dout_emu    <= '0;
    end else begin
      if (cmd_load) stim_vec <= stim_shadow;
      if (capture)  out_shadow <= resp_vec;
      if (rd_emu)   Dout_emu <= rd_byte;
      for (int i = 0; i < NUM_STIM_BYTES; i++) begin
        if (cmd_wr && (Addr_emu == ADDR_W'(i))) stim_shadow[8*i +: 8] <= Din_emu;
      end
    end
  end

endmodule
